// File: rtl/tpu_act_pkg.sv
// Shared definitions for the activation and pooling datapath: FP16 constants,
// activation type codes, pooling state encoding and the max-pool ordering function.
package tpu_act_pkg;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_SIX  = 16'h4600;
  localparam logic [15:0] FP16_HALF = 16'h3800;

  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,
    ACT_RELU    = 3'd1,
    ACT_RELU6   = 3'd2,
    ACT_SIGMOID = 3'd3,
    ACT_TANH    = 3'd4
  } act_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pool_state_t;

  // Strict a > b. INT operands arrive sign-extended to 16 bits. FP16 maps to a
  // signed sign-magnitude key so -0 and +0 compare equal and NaNs sort by bits.
  function automatic logic pool_gt(input logic [15:0] a, input logic [15:0] b,
                                   input logic is_fp);
    logic signed [16:0] ka, kb;
    if (is_fp) begin
      ka = a[15] ? -$signed({2'b00, a[14:0]}) : $signed({2'b00, a[14:0]});
      kb = b[15] ? -$signed({2'b00, b[14:0]}) : $signed({2'b00, b[14:0]});
    end else begin
      ka = $signed({a[15], a});
      kb = $signed({b[15], b});
    end
    return ka > kb;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer of partial maxima: synchronous write, combinational read.
module pool_line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool stage: row-major pixels in, one pooled pixel
// per window out through a single-entry output register.
//   state    | meaning
//   ST_IDLE  | waiting for start; cfg checked on start
//   ST_RUN   | accepting pixels of the frame
//   ST_FLUSH | all pixels taken; waiting for the final output handshake
module maxpool2x2_stream #(
  parameter int DATA_WIDTH        = 16,
  parameter int IS_FLOATING_POINT = 1,
  parameter int MAX_COLS          = 64,
  parameter int DIM_W             = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_cols,
  input  logic [DIM_W-1:0]      cfg_rows,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  import tpu_act_pkg::*;

  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  pool_state_t           state;
  logic [DIM_W-1:0]      cols_q, rows_q, col, row;
  logic [DATA_WIDTH-1:0] pair, pm, lb_rdata, win_max;
  logic                  in_fire, out_fire, col_end, last_in, win_done, lb_we, cfg_ok;

  // Ties keep the first operand, so the earliest pixel of a window wins.
  function automatic logic [DATA_WIDTH-1:0] first_max(input logic [DATA_WIDTH-1:0] first,
                                                      input logic [DATA_WIDTH-1:0] second);
    return pool_gt(16'(signed'(second)), 16'(signed'(first)), IS_FLOATING_POINT != 0)
           ? second : first;
  endfunction

  assign in_ready = (state == ST_RUN) & (~out_valid | out_ready);
  assign busy     = (state != ST_IDLE);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign col_end  = (col == cols_q - DIM_W'(1));
  assign last_in  = in_fire & col_end & (row == rows_q - DIM_W'(1));
  assign win_done = in_fire & col[0] & row[0];
  assign lb_we    = in_fire & col[0] & ~row[0];
  assign pm       = first_max(pair, in_data);
  assign win_max  = first_max(lb_rdata, pm);
  assign cfg_ok   = ~cfg_cols[0] & ~cfg_rows[0] & (cfg_cols != '0) & (cfg_rows != '0)
                  & (cfg_cols <= DIM_W'(MAX_COLS));

  pool_line_buf #(.DEPTH(LB_DEPTH), .WIDTH(DATA_WIDTH), .AW(AW)) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (col[AW:1]),
    .wdata (pm),
    .raddr (col[AW:1]),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cols_q    <= '0;
      rows_q    <= '0;
      col       <= '0;
      row       <= '0;
      pair      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              cols_q <= cfg_cols;
              rows_q <= cfg_rows;
              col    <= '0;
              row    <= '0;
              state  <= ST_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            if (col_end) begin
              col <= '0;
              row <= last_in ? '0 : row + DIM_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
            if (last_in) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (out_fire) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (in_fire & ~col[0]) pair <= in_data;

      // A completing window refills the register on the same edge it drains.
      if (win_done) begin
        out_valid <= 1'b1;
        out_data  <= win_max;
        out_last  <= last_in;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: one INT8 instance and one FP16 instance,
// stimulus steered to whichever is selected.
module tb_maxpool2x2_stream;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, start_f = 1'b0;
  logic [6:0]  cfg_cols = 7'd0, cfg_rows = 7'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b1;

  logic        in_ready_i, out_valid_i, out_last_i, busy_i, done_i, cfg_err_i;
  logic [7:0]  out_data_i;
  logic        in_ready_f, out_valid_f, out_last_f, busy_f, done_f, cfg_err_f;
  logic [15:0] out_data_f;

  logic        sel_fp = 1'b0, stall_mode = 1'b0, sb_en = 1'b1;
  logic        in_ready_m, out_valid_m, out_last_m, busy_m, done_m, cfg_err_m;
  logic [15:0] out_data_m;

  int          n_chk = 0, n_err = 0, cyc = 0, last_hs_cyc = -10;
  exp_t        sb_q[$];
  logic [15:0] pix [0:255];

  assign in_ready_m  = sel_fp ? in_ready_f  : in_ready_i;
  assign out_valid_m = sel_fp ? out_valid_f : out_valid_i;
  assign out_last_m  = sel_fp ? out_last_f  : out_last_i;
  assign busy_m      = sel_fp ? busy_f      : busy_i;
  assign done_m      = sel_fp ? done_f      : done_i;
  assign cfg_err_m   = sel_fp ? cfg_err_f   : cfg_err_i;
  assign out_data_m  = sel_fp ? out_data_f  : {8'h00, out_data_i};

  maxpool2x2_stream #(.DATA_WIDTH(8), .IS_FLOATING_POINT(0), .MAX_COLS(64), .DIM_W(7)) u_int (
    .clk(clk), .rst_n(rst_n), .start(start_i), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid & ~sel_fp), .in_ready(in_ready_i), .in_data(in_data[7:0]),
    .out_valid(out_valid_i), .out_ready(out_ready), .out_data(out_data_i),
    .out_last(out_last_i), .busy(busy_i), .done(done_i), .cfg_err(cfg_err_i));

  maxpool2x2_stream #(.DATA_WIDTH(16), .IS_FLOATING_POINT(1), .MAX_COLS(64), .DIM_W(7)) u_fp (
    .clk(clk), .rst_n(rst_n), .start(start_f), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid & sel_fp), .in_ready(in_ready_f), .in_data(in_data),
    .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f),
    .out_last(out_last_f), .busy(busy_f), .done(done_f), .cfg_err(cfg_err_f));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : ready_gen
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      out_ready = stall_mode ? (k % 3 == 0) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ord_key(input logic [15:0] v, input logic fp);
    if (fp) return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    return int'($signed(v[7:0]));
  endfunction

  // Output monitor: sampled mid-cycle, a valid&ready here is the upcoming handshake.
  initial begin : monitor
    logic [15:0] held_d;
    logic        held_l, held_ok;
    exp_t        e;
    held_ok = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_en && out_valid_m) begin
        if (held_ok) begin
          chk("hold_data", out_data_m, held_d);
          chk("hold_last", out_last_m, held_l);
        end
        if (out_ready) begin
          held_ok = 1'b0;
          if (sb_q.size() == 0) begin
            chk("unexpected_output", out_data_m, 32'hdead);
          end else begin
            e = sb_q.pop_front();
            chk("out_data", out_data_m, e.d);
            chk("out_last", out_last_m, e.l);
            if (e.l) last_hs_cyc = cyc;
          end
        end else begin
          held_d  = out_data_m;
          held_l  = out_last_m;
          held_ok = 1'b1;
          chk("in_ready_stalled", in_ready_m, 1'b0);
        end
      end else begin
        held_ok = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    if (sel_fp) start_f = 1'b1; else start_i = 1'b1;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic drive_pixel(input logic [15:0] d);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready_m;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic push_expected(input int cols, input int rows);
    logic [15:0] p [4];
    logic [15:0] best;
    exp_t        e;
    for (int wr = 0; wr < rows / 2; wr++) begin
      for (int wc = 0; wc < cols / 2; wc++) begin
        p[0] = pix[(2*wr)*cols + 2*wc];
        p[1] = pix[(2*wr)*cols + 2*wc + 1];
        p[2] = pix[(2*wr+1)*cols + 2*wc];
        p[3] = pix[(2*wr+1)*cols + 2*wc + 1];
        best = p[0];
        for (int k = 1; k < 4; k++)
          if (ord_key(p[k], sel_fp) > ord_key(best, sel_fp)) best = p[k];
        e.d = sel_fp ? best : {8'h00, best[7:0]};
        e.l = (wr == rows/2 - 1) && (wc == cols/2 - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done();
    logic seen;
    int   hs;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done_m;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      hs = last_hs_cyc;
      chk("done_latency", cyc, hs + 1);
      chk("busy_at_done", busy_m, 0);
      chk("sb_drained", sb_q.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done_m, 0);
    end
  endtask

  task automatic run_frame(input int cols, input int rows, input int mid_start);
    push_expected(cols, rows);
    cfg_cols = 7'(cols);
    cfg_rows = 7'(rows);
    pulse_start();
    chk("busy_after_start", busy_m, 1);
    for (int k = 0; k < cols * rows; k++) begin
      if (k == mid_start) begin
        in_valid = 1'b0;
        cfg_cols = 7'd4;
        cfg_rows = 7'd4;
        pulse_start();
        @(negedge clk);
        chk("mid_start_busy", busy_m, 1);
        chk("mid_start_cfg_err", cfg_err_m, 0);
        @(posedge clk);
        #1;
      end
      drive_pixel(pix[k]);
    end
    in_valid = 1'b0;
    wait_done();
  endtask

  task automatic bad_cfg(input int cols, input int rows);
    cfg_cols = 7'(cols);
    cfg_rows = 7'(rows);
    pulse_start();
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err_m, 1);
    chk("cfg_err_busy", busy_m, 0);
    chk("cfg_err_in_ready", in_ready_m, 0);
    @(negedge clk);
    chk("cfg_err_clears", cfg_err_m, 0);
    chk("cfg_err_still_idle", busy_m, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    #23;
    @(negedge clk);
    chk("rst_out_valid", out_valid_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_cfg_err", cfg_err_m, 0);
    chk("rst_in_ready", in_ready_m, 0);
    chk("rst_out_data", out_data_m, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // INT8 4x4 ramp: windows give 5, 7, 13, 15
    for (int i = 0; i < 16; i++) pix[i] = 16'(i);
    run_frame(4, 4, -1);

    stall_mode = 1'b1;
    run_frame(4, 4, -1);

    // Signed values across a wider frame under stall
    for (int i = 0; i < 32; i++) pix[i] = 16'($urandom_range(0, 255));
    run_frame(8, 4, -1);
    stall_mode = 1'b0;

    sel_fp = 1'b1;
    pix[0] = 16'hBC00; pix[1] = 16'hC000; pix[2] = 16'h8000; pix[3] = 16'h0000;
    run_frame(2, 2, -1);
    pix[0] = 16'h3C00; pix[1] = 16'h4600; pix[2] = 16'hC600; pix[3] = 16'h4000;
    run_frame(2, 2, -1);
    sel_fp = 1'b0;

    bad_cfg(3, 4);
    bad_cfg(4, 0);
    bad_cfg(66, 2);

    // Abort a frame with reset after six pixels
    sb_en = 1'b0;
    for (int i = 0; i < 16; i++) pix[i] = 16'($urandom_range(0, 255));
    cfg_cols = 7'd4;
    cfg_rows = 7'd4;
    pulse_start();
    for (int k = 0; k < 6; k++) drive_pixel(pix[k]);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid_i, 0);
    chk("midrst_busy", busy_i, 0);
    chk("midrst_in_ready", in_ready_i, 0);
    chk("midrst_out_last", out_last_i, 0);
    chk("midrst_out_data", out_data_i, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", done_i, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_en = 1'b1;
    for (int i = 0; i < 16; i++) pix[i] = 16'($urandom_range(0, 255));
    run_frame(4, 4, -1);

    // Mid-frame start with different dims must be ignored
    for (int i = 0; i < 16; i++) pix[i] = 16'($urandom_range(0, 255));
    run_frame(8, 2, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
